// File: rtl/tdm_demux_1_8_v.sv
// tdm_demux_1_8_v: receive end of an 8-slot TDM serial link.
// Samples i_bit once per enabled cycle while stepping a slot counter 0..7 and
// routes each bit to its lane. It reassembles the 8-bit code word, with slot k
// landing in o_code[k], and flags a completed word with a one-cycle o_valid.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_en        sample enable (0 stalls the frame)
//   i_start     frame sync, marks the slot-0 cycle
//   i_bit       serial data line
//   o_sel_code  slot index sampled this cycle (combinational, 0 in IDLE)
//   o_lane      one-hot demux of i_bit onto the current slot (combinational)
//   o_code      registered reassembled word
//   o_valid     one-cycle pulse, o_code updated
//   o_busy      frame in progress
//   o_err       one-cycle pulse, frame aborted by a premature i_start
module tdm_demux_1_8_v #(
  parameter int unsigned HOLD_LAST = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_start,
  input  logic       i_bit,
  output logic [2:0] o_sel_code,
  output logic [7:0] o_lane,
  output logic [7:0] o_code,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_err
);

  localparam int unsigned CODE_W = 8;
  localparam int unsigned SLOT_W = 3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]        state_q,  state_d;
  logic [SLOT_W-1:0] slot_q,   slot_d;
  logic [CODE_W-1:0] shadow_q, shadow_d;
  logic [CODE_W-1:0] code_q,   code_d;
  logic              valid_q,  valid_d;
  logic              err_q,    err_d;
  logic              sample_c;

  // A sample is taken on an enabled frame start or any enabled ACTIVE cycle;
  // gated by reset so the combinational outputs read 0 while in reset.
  assign sample_c = i_rst_n & i_en & ((state_q == ST_IDLE) ? i_start : 1'b1);

  // Combinational demux onto the lane of the current slot.
  always_comb begin
    o_lane = '0;
    if (sample_c) begin
      o_lane[slot_q] = i_bit;
    end
  end

  // Next-state and frame assembly.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    // Without HOLD_LAST the word is shown only for the o_valid cycle.
    code_d   = (HOLD_LAST == 0 && valid_q) ? '0 : code_q;

    case (state_q)
      ST_IDLE: begin
        if (i_en && i_start) begin
          shadow_d = CODE_W'(i_bit);
          slot_d   = SLOT_W'(1);
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (i_en) begin
          if (i_start) begin
            // Premature sync: drop the partial frame, this cycle is slot 0.
            err_d    = 1'b1;
            shadow_d = CODE_W'(i_bit);
            slot_d   = SLOT_W'(1);
          end else if (slot_q == SLOT_W'(7)) begin
            code_d   = {i_bit, shadow_q[6:0]};
            valid_d  = 1'b1;
            slot_d   = '0;
            state_d  = ST_IDLE;
          end else begin
            shadow_d[slot_q] = i_bit;
            slot_d           = slot_q + SLOT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        slot_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      shadow_q <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign o_sel_code = slot_q;
  assign o_code     = code_q;
  assign o_valid    = valid_q;
  assign o_busy     = (state_q == ST_ACTIVE);
  assign o_err      = err_q;

endmodule

// File: tb/tb_tdm_demux_1_8_v.sv
// Directed bench for tdm_demux_1_8_v: one instance holding the last word,
// one clearing it, driven from the same stimulus.
module tb_tdm_demux_1_8_v;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       start;
  logic       bit_in;
  logic [2:0] sel1, sel0;
  logic [7:0] lane1, lane0;
  logic [7:0] code1, code0;
  logic       valid1, valid0;
  logic       busy1, busy0;
  logic       err1, err0;

  int total = 0;
  int bad   = 0;

  logic [2:0] sel_s;
  logic [7:0] lane_s;
  logic [7:0] lane0_s;

  tdm_demux_1_8_v #(.HOLD_LAST(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_bit(bit_in),
    .o_sel_code(sel1), .o_lane(lane1), .o_code(code1), .o_valid(valid1),
    .o_busy(busy1), .o_err(err1)
  );

  tdm_demux_1_8_v #(.HOLD_LAST(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_bit(bit_in),
    .o_sel_code(sel0), .o_lane(lane0), .o_code(code0), .o_valid(valid0),
    .o_busy(busy0), .o_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       st;
    logic       b;
    logic [2:0] sel;
    logic [7:0] lane;
    logic       valid;
    logic [7:0] code;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic s, input logic b,
                     input logic [2:0] sel, input logic [7:0] lane,
                     input logic v, input logic [7:0] code,
                     input logic busy, input logic err);
    vec_t r;
    r.en = e; r.st = s; r.b = b; r.sel = sel; r.lane = lane;
    r.valid = v; r.code = code; r.busy = busy; r.err = err;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after an edge, capture combinational outputs,
  // then step past the next rising edge so registered outputs are settled.
  task automatic tick(input logic e, input logic s, input logic b);
    en = e; start = s; bit_in = b;
    #1;
    sel_s   = sel1;
    lane_s  = lane1;
    lane0_s = lane0;
    @(posedge clk);
    #1;
  endtask

  // Full frame LSB first, checking lane routing and the completion pulse.
  task automatic send_frame(input logic [7:0] w, input string tag);
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, k == 0, w[k]);
      chk({tag, " sel"}, 8'(sel_s), 8'(k));
      chk({tag, " lane"}, lane_s, 8'(w[k]) << k);
      if (k < 7) chk({tag, " early valid"}, 8'(valid1), 8'h00);
    end
    chk({tag, " valid"}, 8'(valid1), 8'h01);
    chk({tag, " code"}, code1, w);
    chk({tag, " busy after"}, 8'(busy1), 8'h00);
  endtask

  int vcnt;
  int ecnt;

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; bit_in = 1'b0;
    #12;
    chk("reset sel",   8'(sel1),   8'h00);
    chk("reset lane",  lane1,      8'h00);
    chk("reset code",  code1,      8'h00);
    chk("reset valid", 8'(valid1), 8'h00);
    chk("reset busy",  8'(busy1),  8'h00);
    chk("reset err",   8'(err1),   8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 8'hA5 (bits 1,0,1,0,0,1,0,1).
    add(1,1,1, 3'd0, 8'h01, 0, 8'h00, 1, 0);
    add(1,0,0, 3'd1, 8'h00, 0, 8'h00, 1, 0);
    add(1,0,1, 3'd2, 8'h04, 0, 8'h00, 1, 0);
    add(1,0,0, 3'd3, 8'h00, 0, 8'h00, 1, 0);
    add(1,0,0, 3'd4, 8'h00, 0, 8'h00, 1, 0);
    add(1,0,1, 3'd5, 8'h20, 0, 8'h00, 1, 0);
    add(1,0,0, 3'd6, 8'h00, 0, 8'h00, 1, 0);
    add(1,0,1, 3'd7, 8'h80, 1, 8'hA5, 0, 0);
    add(0,0,1, 3'd0, 8'h00, 0, 8'hA5, 0, 0);
    // Frame 8'h3C (bits 0,0,1,1,1,1,0,0) with a 3-cycle stall after slot 2.
    add(1,1,0, 3'd0, 8'h00, 0, 8'hA5, 1, 0);
    add(1,0,0, 3'd1, 8'h00, 0, 8'hA5, 1, 0);
    add(1,0,1, 3'd2, 8'h04, 0, 8'hA5, 1, 0);
    add(0,0,1, 3'd3, 8'h00, 0, 8'hA5, 1, 0);
    add(0,1,1, 3'd3, 8'h00, 0, 8'hA5, 1, 0);
    add(0,0,1, 3'd3, 8'h00, 0, 8'hA5, 1, 0);
    add(1,0,1, 3'd3, 8'h08, 0, 8'hA5, 1, 0);
    add(1,0,1, 3'd4, 8'h10, 0, 8'hA5, 1, 0);
    add(1,0,1, 3'd5, 8'h20, 0, 8'hA5, 1, 0);
    add(1,0,0, 3'd6, 8'h00, 0, 8'hA5, 1, 0);
    add(1,0,0, 3'd7, 8'h00, 1, 8'h3C, 0, 0);
    add(0,0,0, 3'd0, 8'h00, 0, 8'h3C, 0, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].en, tbl[i].st, tbl[i].b);
      chk($sformatf("v%0d sel", i),    8'(sel_s),   8'(tbl[i].sel));
      chk($sformatf("v%0d lane", i),   lane_s,      tbl[i].lane);
      chk($sformatf("v%0d lane0", i),  lane0_s,     tbl[i].lane);
      chk($sformatf("v%0d valid", i),  8'(valid1),  8'(tbl[i].valid));
      chk($sformatf("v%0d code", i),   code1,       tbl[i].code);
      chk($sformatf("v%0d code0", i),  code0,       tbl[i].valid ? tbl[i].code : 8'h00);
      chk($sformatf("v%0d busy", i),   8'(busy1),   8'(tbl[i].busy));
      chk($sformatf("v%0d err", i),    8'(err1),    8'(tbl[i].err));
      chk($sformatf("v%0d err0", i),   8'(err0),    8'(tbl[i].err));
    end

    // Back-to-back 8'hFF then 8'h01, no idle cycle between them.
    vcnt = 0;
    for (int c = 0; c < 16; c++) begin
      logic [7:0] w;
      w = (c < 8) ? 8'hFF : 8'h01;
      tick(1'b1, (c % 8) == 0, w[c % 8]);
      if (valid1) vcnt++;
      if (c == 7)  begin chk("b2b valid1", 8'(valid1), 8'h01); chk("b2b code1", code1, 8'hFF); end
      if (c == 15) begin chk("b2b valid2", 8'(valid1), 8'h01); chk("b2b code2", code1, 8'h01); end
    end
    chk("b2b pulses", 8'(vcnt), 8'd2);

    // Abort: establish 8'h77, start another frame, resync at slot 4 into 8'h81.
    send_frame(8'h77, "f77");
    vcnt = 0; ecnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, k == 0, 1'b0);
      if (valid1) vcnt++;
      if (err1) ecnt++;
    end
    tick(1'b1, 1'b1, 1'b1);
    chk("abort sel", 8'(sel_s), 8'd4);
    chk("abort lane", lane_s, 8'h10);
    chk("abort err", 8'(err1), 8'h01);
    chk("abort busy", 8'(busy1), 8'h01);
    chk("abort code", code1, 8'h77);
    if (valid1) vcnt++;
    if (err1) ecnt++;
    // Remaining slots 1..7 of 8'h81.
    for (int k = 1; k < 8; k++) begin
      tick(1'b1, 1'b0, k == 7);
      chk("abort resume sel", 8'(sel_s), 8'(k));
      if (k < 7) chk("abort hold code", code1, 8'h77);
      if (valid1) vcnt++;
      if (err1) ecnt++;
    end
    chk("abort new code", code1, 8'h81);
    chk("abort valid count", 8'(vcnt), 8'd1);
    chk("abort err count", 8'(ecnt), 8'd1);

    // Asynchronous reset mid-frame at slot 5.
    for (int k = 0; k < 5; k++) tick(1'b1, k == 0, k[0]);
    en = 1'b1; start = 1'b0; bit_in = 1'b1;
    #1;
    chk("pre-rst sel", 8'(sel1), 8'd5);
    rst_n = 1'b0;
    #1;
    chk("rst sel",   8'(sel1),   8'h00);
    chk("rst lane",  lane1,      8'h00);
    chk("rst code",  code1,      8'h00);
    chk("rst valid", 8'(valid1), 8'h00);
    chk("rst busy",  8'(busy1),  8'h00);
    chk("rst err",   8'(err1),   8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vcnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (valid1 || err1) vcnt++;
    end
    chk("post-rst quiet", 8'(vcnt), 8'd0);
    send_frame(8'h5A, "f5A");

    // HOLD_LAST: 1 keeps the word, 0 clears it after the valid cycle.
    send_frame(8'hC3, "fC3");
    chk("hl0 valid", 8'(valid0), 8'h01);
    chk("hl0 code", code0, 8'hC3);
    tick(1'b0, 1'b0, 1'b0);
    chk("hl0 cleared", code0, 8'h00);
    chk("hl1 held", code1, 8'hC3);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 1'b1);
    chk("hl1 held long", code1, 8'hC3);
    chk("hl0 stays clear", code0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1_8_v.md
Name: tdm_demux_1_8_v

Overview:
- Receive end of the time-division link whose transmit end is our 8:1 mux driven by a slot counter on its select lines. The transmitter puts i_code[k] on the line in slot k.
- This block samples a 1-bit serial line once per enabled cycle and steps its own slot counter 0..7 in lockstep.
- It routes each bit to its lane and reassembles the full 8-bit code word, which it presents with a valid pulse.
- It sits between the serial link and the parallel consumer logic.

Parameters:
- HOLD_LAST, 1, 1: o_code holds the last completed frame until the next frame completes. 0: o_code clears to 8'h00 on the cycle after o_valid.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  sample enable. 0 stalls the frame; no slot advance and no sample.
- i_start  input  1  frame sync. Marks the cycle carrying slot 0.
- i_bit  input  1  serial data line.
- o_sel_code  output  3  slot index being sampled this cycle. 0 in IDLE.
- o_lane  output  8  combinational demux outputs. o_lane[o_sel_code] = i_bit when a sample is taken this cycle; all other bits 0.
- o_code  output  8  registered reassembled word.
- o_valid  output  1  one-cycle pulse: o_code updated this cycle.
- o_busy  output  1  1 while a frame is in progress (ACTIVE).
- o_err  output  1  one-cycle pulse: frame aborted by a premature i_start.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, slot=0, shadow=0, o_code=8'h00, o_valid=0, o_err=0, o_busy=0. Because o_sel_code and o_lane are combinational, they read 0 during reset.
- A sample is taken in a cycle iff (state=IDLE & i_en & i_start) or (state=ACTIVE & i_en).
- IDLE:
  - i_en & i_start: shadow[0] <= i_bit, slot <= 1, go ACTIVE.
  - i_start with i_en=0 is ignored.
  - i_bit is ignored.
- ACTIVE, per cycle:
  - i_en=0: hold slot and shadow; no sample. o_sel_code still shows the held slot; o_lane=0.
  - i_en=1 & i_start=0: shadow[slot] <= i_bit, slot <= slot+1.
  - i_en=1 & slot=7 & i_start=0: o_code <= {i_bit, shadow[6:0]}, o_valid <= 1 next cycle, slot <= 0, go IDLE.
  - i_en=1 & i_start=1 (any slot 1..7): abort the current frame and pulse o_err next cycle. shadow is cleared, then shadow[0] <= i_bit and slot <= 1; stay ACTIVE. o_code is unchanged and o_valid is not asserted.
- Latency: o_code/o_valid update on the clock edge that samples slot 7, so they are visible in the cycle after the slot-7 sample.
- Back-to-back frames: i_start in the cycle immediately after the slot-7 sample is accepted, since the state is already IDLE. Sustained throughput is 8 cycles per frame with no gap.
- o_busy = (state==ACTIVE), registered state decode.
- HOLD_LAST=0: o_code <= 8'h00 on the cycle after o_valid, unless a new frame completes in that same cycle, which cannot happen at fewer than 8 cycles/frame.
- Reset mid-frame: the partial frame is discarded. o_code returns to 8'h00 and no o_valid or o_err is generated.
- Bit ordering: slot k maps to o_code[k], matching the transmitter's i_sel_code=k → i_code[k].

Test Plan:
- Reset, then i_start=1, i_en=1 for one cycle, with i_bit serialising 8'hA5 LSB first over 8 consecutive cycles.
  - o_sel_code steps 0..7 and o_lane[k] follows bit k.
  - The next cycle shows o_code=8'hA5, o_valid=1 for exactly one cycle, o_busy=0.
- Same frame 8'h3C with i_en dropped to 0 for 3 cycles after slot 2.
  - o_sel_code holds 3 and o_lane=0 during the stall.
  - o_code=8'h3C arrives 11 cycles after the start; no o_err.
- Two back-to-back frames 8'hFF then 8'h01 with no idle cycle.
  - o_valid pulses at cycles 8 and 16; o_code reads 8'hFF then 8'h01.
- A frame 8'h77 is completed first so that o_code=8'h77 is established. A second frame is started, then i_start reasserted at slot 4 with i_bit=1, followed by a full frame 8'h81.
  - o_err pulses once; o_code stays 8'h77 until it becomes 8'h81.
  - o_valid is seen only for the completing frames (8'h77 and 8'h81), not for the aborted one.
- Assert i_rst_n=0 asynchronously at slot 5 of a frame.
  - All outputs go to 0 immediately without a clock edge; no o_valid follows.
  - The next full frame 8'h5A decodes correctly.
- HOLD_LAST=0 with frame 8'hC3.
  - o_code=8'hC3 with o_valid for one cycle, then o_code=8'h00 on the following cycle.
- HOLD_LAST=1 with frame 8'hC3.
  - o_code holds 8'hC3 indefinitely.
